// File: rtl/pc_pkg.sv
// ---- pc_pkg : shared types and default vectors for the fetch-address generator, rev 1.0 ----
`default_nettype none

package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    REDIRECT = 2'd1,
    TRAP     = 2'd2
  } pend_kind_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0100_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

`default_nettype wire

// File: rtl/pc_pending_buf.sv
// ---- pc_pending_buf : single-entry buffer for a redirect/trap seen while no launch is possible, rev 1.0 ----
`default_nettype none

module pc_pending_buf
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEF_TRAP_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            capture,
  input  logic            trap_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_target
);

  pend_kind_t kind;

  // A trap always wins; a redirect may only replace a redirect or an empty slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind        <= NONE;
      pend_target <= '0;
    end else if (clear) begin
      kind        <= NONE;
    end else if (capture && trap_in) begin
      kind        <= TRAP;
      pend_target <= TRAP_VECTOR;
    end else if (capture && redirect_in && (kind != TRAP)) begin
      kind        <= REDIRECT;
      pend_target <= redirect_pc;
    end
  end

  assign pend_valid = (kind != NONE);

endmodule

`default_nettype wire

// File: rtl/pc_fetch_gen.sv
// ---- pc_fetch_gen : epoch-tagged fetch-address generator with redirect/trap priority, rev 1.0 ----
`default_nettype none

module pc_fetch_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int              STEP         = 4,
  parameter int              EPOCH_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               trap_valid,
  output logic               fetch_valid,
  input  logic               fetch_ready,
  output logic [XLEN-1:0]    fetch_pc,
  output logic [EPOCH_W-1:0] fetch_epoch,
  output logic [EPOCH_W-1:0] cur_epoch,
  output logic               misaligned_err
);

  localparam int OFF_W = $clog2(STEP);

  state_t             state;
  logic               misaligned;
  logic               event_any;
  logic               launch;
  logic               issue;
  logic               pend_valid;
  logic [XLEN-1:0]    pend_target;
  logic [XLEN-1:0]    base_pc;
  logic [XLEN-1:0]    next_pc;
  logic [EPOCH_W-1:0] epoch_next;

  always_comb begin
    misaligned = redirect_valid && (redirect_pc[OFF_W-1:0] != '0);
    event_any  = trap_valid | redirect_valid;
    launch     = (state == RUN) ? fetch_ready : en;
    issue      = launch & en;
    epoch_next = cur_epoch + EPOCH_W'(event_any);
    base_pc    = (state == BOOT) ? RESET_VECTOR : fetch_pc + XLEN'(STEP);
    if (trap_valid || misaligned) begin
      next_pc = TRAP_VECTOR;
    end else if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (pend_valid) begin
      next_pc = pend_target;
    end else begin
      next_pc = base_pc;
    end
  end

  pc_pending_buf #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_pending (
    .clk         (clk),
    .rst         (rst),
    .clear       (issue),
    .capture     (!issue),
    .trap_in     (trap_valid | misaligned),
    .redirect_in (redirect_valid),
    .redirect_pc (redirect_pc),
    .pend_valid  (pend_valid),
    .pend_target (pend_target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= BOOT;
      fetch_pc       <= RESET_VECTOR;
      fetch_epoch    <= '0;
      cur_epoch      <= '0;
      misaligned_err <= 1'b0;
    end else begin
      misaligned_err <= misaligned && !trap_valid;
      cur_epoch      <= epoch_next;
      if (issue) begin
        fetch_pc    <= next_pc;
        fetch_epoch <= epoch_next;
      end
      case (state)
        BOOT: begin
          // Parking one step below the reset vector lets the first PAUSE launch land on it.
          if (en) state <= RUN;
          else begin
            state    <= PAUSE;
            fetch_pc <= RESET_VECTOR - XLEN'(STEP);
          end
        end
        RUN:     if (fetch_ready && !en) state <= PAUSE;
        PAUSE:   if (en) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

  assign fetch_valid = (state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_gen.sv
// ---- tb_pc_fetch_gen : scoreboard bench with a behavioural fetch-sequence model, rev 1.0 ----
`default_nettype none

module tb_pc_fetch_gen;

  localparam logic [31:0] RV   = 32'h0100_0000;
  localparam logic [31:0] TV   = 32'h0000_0100;
  localparam int          STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, redirect_valid = 1'b0, trap_valid = 1'b0, fetch_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_valid, misaligned_err;
  logic [31:0] fetch_pc;
  logic [1:0]  fetch_epoch, cur_epoch;

  pc_fetch_gen dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .fetch_epoch    (fetch_epoch),
    .cur_epoch      (cur_epoch),
    .misaligned_err (misaligned_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the request stream as a list of issued addresses.
  typedef struct {
    logic [31:0] pc;
    int          ep;
  } req_t;

  req_t        exp_q[$];
  bit          m_has_req, m_first, exp_valid, exp_err;
  int          m_pend_kind;   // 0 empty, 1 redirect, 2 trap
  logic [31:0] m_pend_pc, m_last_pc;
  int          m_epoch;

  task automatic model_reset();
    m_has_req = 0; m_first = 1; m_pend_kind = 0; m_pend_pc = '0;
    m_last_pc = RV; m_epoch = 0; exp_valid = 0; exp_err = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit mis, launch, issue;
    logic [31:0] tgt;
    req_t r;
    mis    = redirect_valid && (redirect_pc % STEP != 0);
    launch = m_has_req ? fetch_ready : en;
    issue  = launch && en;
    exp_err = mis && !trap_valid;
    if (trap_valid || redirect_valid) m_epoch = (m_epoch + 1) % 4;
    if (issue) begin
      if (trap_valid || mis)   tgt = TV;
      else if (redirect_valid) tgt = redirect_pc;
      else if (m_pend_kind != 0) tgt = m_pend_pc;
      else if (m_first)        tgt = RV;
      else                     tgt = m_last_pc + STEP;
      m_pend_kind = 0; m_first = 0; m_last_pc = tgt; m_has_req = 1;
      r.pc = tgt; r.ep = m_epoch;
      exp_q.push_back(r);
    end else begin
      if (m_has_req && fetch_ready) m_has_req = 0;
      if (trap_valid || mis) begin
        m_pend_kind = 2; m_pend_pc = TV;
      end else if (redirect_valid && m_pend_kind != 2) begin
        m_pend_kind = 1; m_pend_pc = redirect_pc;
      end
    end
    exp_valid = m_has_req;
  endtask

  // Monitor: compares the presented request against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", {31'b0, fetch_valid}, {31'b0, exp_valid});
      chk("cur_epoch", {30'b0, cur_epoch}, 32'(m_epoch));
      chk("misaligned_err", {31'b0, misaligned_err}, {31'b0, exp_err});
      if (fetch_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", fetch_pc, 32'hDEAD_BEEF);
        end else begin
          chk("fetch_pc", fetch_pc, exp_q[0].pc);
          chk("fetch_epoch", {30'b0, fetch_epoch}, 32'(exp_q[0].ep));
          if (fetch_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit e, input bit r, input bit t, input bit v, input logic [31:0] p);
    en = e; fetch_ready = r; trap_valid = t; redirect_valid = v; redirect_pc = p;
    @(posedge clk);
    #2;
    model_step();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    en = 0; fetch_ready = 0; trap_valid = 0; redirect_valid = 0; redirect_pc = '0;
    model_reset();
    #1;
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_pc", fetch_pc, RV);
    chk("rst_fetch_epoch", {30'b0, fetch_epoch}, 32'd0);
    chk("rst_cur_epoch", {30'b0, cur_epoch}, 32'd0);
    chk("rst_err", {31'b0, misaligned_err}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #7;
    reset_dut();
    // Sequential stream from the reset vector.
    repeat (4) cyc(1, 1, 0, 0, 0);
    // Stalled request with a redirect captured on the first stall cycle.
    cyc(1, 0, 0, 1, 32'h0100_0040);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    // Simultaneous trap and redirect.
    cyc(1, 1, 1, 1, 32'h0000_0200);
    repeat (2) cyc(1, 1, 0, 0, 0);
    // Misaligned redirect.
    cyc(1, 1, 0, 1, 32'h0100_0042);
    repeat (2) cyc(1, 1, 0, 0, 0);
    // Pause with a held request, redirect while paused.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'h0000_0300);
    cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    // Pending trap followed by a redirect while stalled.
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 32'h0000_0500);
    repeat (3) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 32'h0000_0600);
    cyc(1, 1, 0, 1, 32'h0000_0700);
    // Address wrap at the top of the space.
    cyc(1, 1, 0, 1, 32'hFFFF_FFFC);
    repeat (3) cyc(1, 1, 0, 0, 0);
    // Reset mid-stall, then boot with en low.
    cyc(1, 0, 0, 1, 32'h0000_0800);
    reset_dut();
    cyc(0, 1, 0, 1, 32'h0000_0900);
    cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    reset_dut();
    cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] p;
      p = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) p = p | 32'(($urandom_range(1, 3)));
      cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 12) == 0), ($urandom_range(0, 4) == 0), p);
      if ($urandom_range(0, 999) == 0) reset_dut();
    end
    repeat (2) cyc(1, 1, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_fetch_gen.md
# pc_fetch_gen

Parametrised fetch-address generator that replaces the single-register program counter at the head of the fetch stage. It issues instruction addresses to instruction memory over a valid/ready handshake and sequences them by a fixed step. It applies branch/jump redirects and traps by priority, and buffers a redirect that arrives while a request is stalled. Every request carries an epoch tag so fetch and decode can discard responses from the wrong path.

## Interface
- XLEN, 32, address width
- RESET_VECTOR, 32'h0100_0000, first fetch address after reset
- TRAP_VECTOR, 32'h0000_0100, target on trap or misaligned redirect
- STEP, 4, byte increment per sequential fetch; power of two, ≥ 2
- EPOCH_W, 2, epoch tag width; counter wraps modulo 2^EPOCH_W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  advance enable; 0 = no new request after the current one completes
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  XLEN  redirect target
- trap_valid  in  1  trap this cycle
- fetch_valid  out  1  request valid
- fetch_ready  in  1  imem accepts request
- fetch_pc  out  XLEN  request address
- fetch_epoch  out  EPOCH_W  epoch of current request
- cur_epoch  out  EPOCH_W  latest epoch; a response is stale if its tag differs
- misaligned_err  out  1  one-cycle pulse: redirect target not STEP-aligned

## Operation
- States:
  - BOOT: reset state. Always moves to RUN, or to PAUSE if en = 0.
  - RUN: fetch_valid = 1.
  - PAUSE: fetch_valid = 0.
- Handshake:
  - A transfer occurs on a cycle with fetch_valid & fetch_ready.
  - While fetch_valid = 1 and not accepted, fetch_pc and fetch_epoch hold stable.
  - fetch_valid does not drop before acceptance, even if en falls.
- Launch cycle: a transfer in RUN, or any cycle in BOOT or PAUSE with en = 1.
  - In a launch cycle with en = 1, the next request's fetch_pc is chosen by priority:
    1. trap_valid: TRAP_VECTOR
    2. redirect_valid with misaligned target (redirect_pc[log2(STEP)-1:0] ≠ 0): TRAP_VECTOR, and misaligned_err pulses
    3. redirect_valid, aligned: redirect_pc
    4. pending buffer valid: pending target
    5. otherwise: fetch_pc + STEP, wrapping modulo 2^XLEN
  - BOOT issues RESET_VECTOR, using steps 1–4 only.
- Event capture (non-launch cycles): trap or redirect is written to the single pending buffer.
  - A trap overwrites any pending entry.
  - A redirect overwrites a pending redirect but never a pending trap.
  - A misaligned redirect is stored as a trap.
  - The pending buffer clears when consumed.
- Epoch:
  - cur_epoch increments once per cycle with trap_valid | redirect_valid, whether applied or captured.
  - A simultaneous trap and redirect counts as one increment.
  - fetch_epoch takes cur_epoch's post-update value at each launch.
- en = 0 during a launch cycle: go to PAUSE. Any event that cycle is captured, not lost.
- PAUSE with en = 1: launch as above, go to RUN.

## Timing
- rst asserted takes effect immediately, without waiting for a clock edge:
  - fetch_valid = 0, fetch_pc = RESET_VECTOR
  - fetch_epoch = 0, cur_epoch = 0
  - misaligned_err = 0, pending buffer empty, state BOOT
- First request: fetch_valid = 1 at the first rising edge after rst deasserts, provided en = 1.
- Redirect latency: an event in a launch cycle appears on fetch_pc the next cycle.
- A captured event launches one cycle after the held request is accepted.
- Sustained throughput: one request per cycle while fetch_ready = 1.
- misaligned_err is registered: it is high for exactly the cycle after the offending redirect.
- rst asserted mid-stall discards the pending buffer and the outstanding request.

## Structure
- Shared package pc_pkg:
  - state enum (BOOT, RUN, PAUSE)
  - default RESET_VECTOR and TRAP_VECTOR
  - pending-kind enum (NONE, REDIRECT, TRAP)
- One sub-module, pc_pending_buf: holds the pending target and kind, with the overwrite rules above.
- The priority mux, state register and epoch counter stay in the top module.

## Test plan
- Reset release, en = 1, fetch_ready = 1: fetch_pc = 0x0100_0000, 0x0100_0004, 0x0100_0008 on consecutive cycles; epoch 0.
- fetch_ready = 0 for 3 cycles with a redirect to 0x0100_0040 in cycle 1:
  - fetch_pc held; cur_epoch = 1 while fetch_epoch = 0.
  - After acceptance: fetch_pc = 0x0100_0040, fetch_epoch = 1.
- Same cycle: trap_valid and redirect_valid (0x200): next fetch_pc = 0x100; cur_epoch increments by exactly 1.
- Redirect to 0x0100_0042: misaligned_err high for one cycle; next fetch_pc = 0x100.
- en = 0 mid-stream: the held request completes, fetch_valid drops. A redirect during PAUSE to 0x300, then en = 1: first request is 0x300.
- Pending trap then a later redirect, both while stalled: trap wins (0x100). cur_epoch advances by 2, then wraps 3 → 0.
